// File: rtl/pooling_stream.sv
// pooling_stream: raster-order streaming POOLxPOOL pooling engine.
// One row of partial window results (acc) is kept. A pooled pixel is
// emitted on the cycle after the pixel that completes its window.
module pooling_stream #(
    parameter int RESOLUTION = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int POOL       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [RESOLUTION-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RESOLUTION-1:0] out_pixel,
    output logic                  out_last,
    output logic                  sof_err
);
    localparam int OUT_W = IMG_W / POOL;
    localparam int OUT_H = IMG_H / POOL;
    localparam int PL    = $clog2(POOL);
    localparam int SH    = 2 * PL;
    localparam int ACC_W = RESOLUTION + SH;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int OXW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OYW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ACC_W-1:0]      acc_q [OUT_W];
    logic [ACC_W-1:0]      acc_d [OUT_W];
    logic                  mode_q, mode_d;
    logic                  out_valid_q, out_valid_d;
    logic [RESOLUTION-1:0] out_pixel_q, out_pixel_d;
    logic                  out_last_q, out_last_d;
    logic                  sof_err_q, sof_err_d;

    logic                  accept;
    logic [XW-1:0]         ex;
    logic [YW-1:0]         ey;
    logic [OXW-1:0]        ox;
    logic [OYW-1:0]        oy;
    logic                  at_origin;
    logic                  win_first;
    logic                  win_done;
    logic [ACC_W-1:0]      cur;
    logic [ACC_W-1:0]      pix_ext;
    logic [ACC_W-1:0]      upd;
    logic [RESOLUTION-1:0] avg_pix;

    // A held, unconsumed result blocks the input.
    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_last  = out_last_q;
    assign sof_err   = sof_err_q;

    // Effective position of the incoming pixel; a start-of-frame pixel is always (0,0).
    always_comb begin
        ex        = in_sof ? '0 : x_q;
        ey        = in_sof ? '0 : y_q;
        ox        = OXW'(ex >> PL);
        oy        = OYW'(ey >> PL);
        at_origin = (ex == '0) && (ey == '0);
        win_first = (ex[PL-1:0] == '0) && (ey[PL-1:0] == '0);
        win_done  = (ex[PL-1:0] == PL'(POOL - 1)) && (ey[PL-1:0] == PL'(POOL - 1));
    end

    // Updated window value: load on the window's first pixel, else sum or max.
    always_comb begin
        cur     = acc_q[ox];
        pix_ext = ACC_W'(in_pixel);
        if (win_first) begin
            upd = pix_ext;
        end else if (mode_q) begin
            upd = (pix_ext > cur) ? pix_ext : cur;
        end else begin
            upd = cur + pix_ext;
        end
        // Average of POOL*POOL samples is a floor shift by 2*log2(POOL).
        avg_pix = upd[ACC_W-1:SH];
    end

    // Next-state: counters, accumulators, mode latch and output register.
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_last_d  = out_last_q;
        sof_err_d   = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            // Restart mid-frame: the partial windows are simply overwritten later.
            sof_err_d = in_sof && ((x_q != '0) || (y_q != '0));
            if (at_origin) begin
                mode_d = mode;
            end
            acc_d[ox] = upd;

            if (ex == XW'(IMG_W - 1)) begin
                x_d = '0;
                y_d = (ey == YW'(IMG_H - 1)) ? '0 : ey + 1'b1;
            end else begin
                x_d = ex + 1'b1;
                y_d = ey;
            end

            // A completing pixel loads a new result even in the consume cycle.
            if (win_done) begin
                out_valid_d = 1'b1;
                out_pixel_d = mode_q ? upd[RESOLUTION-1:0] : avg_pix;
                out_last_d  = (ox == OXW'(OUT_W - 1)) && (oy == OYW'(OUT_H - 1));
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            for (int i = 0; i < OUT_W; i++) begin
                acc_q[i] <= '0;
            end
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_last_q  <= out_last_d;
            sof_err_q   <= sof_err_d;
        end
    end

endmodule

// File: tb/tb_pooling_stream.sv
// Directed bench for pooling_stream: a 4x4 instance (a_*) and a
// default 28x28 instance (b_*), checked with immediate assertions.
module tb_pooling_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4x4, POOL=2 instance
    logic       a_rst, a_mode, a_in_valid, a_in_ready, a_in_sof;
    logic [7:0] a_in_pixel, a_out_pixel;
    logic       a_out_valid, a_out_ready, a_out_last, a_sof_err;

    // default 28x28, POOL=2 instance
    logic       b_rst, b_mode, b_in_valid, b_in_ready, b_in_sof;
    logic [7:0] b_in_pixel, b_out_pixel;
    logic       b_out_valid, b_out_ready, b_out_last, b_sof_err;

    pooling_stream #(.RESOLUTION(8), .IMG_W(4), .IMG_H(4), .POOL(2)) dut_a (
        .clk(clk), .reset(a_rst), .mode(a_mode),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof),
        .in_pixel(a_in_pixel), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_pixel(a_out_pixel), .out_last(a_out_last), .sof_err(a_sof_err)
    );

    pooling_stream dut_b (
        .clk(clk), .reset(b_rst), .mode(b_mode),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
        .in_pixel(b_in_pixel), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_pixel(b_out_pixel), .out_last(b_out_last), .sof_err(b_sof_err)
    );

    int cmp_cnt = 0;
    int bad_cnt = 0;

    // Handshake recorders
    int cyc = 0;
    int a_q_val[$];
    int a_q_last[$];
    int a_q_cyc[$];
    int a_acc_cyc[$];
    int a_sof_cnt = 0;
    int b_q_val[$];
    int b_q_last[$];

    always @(posedge clk) begin
        if (a_out_valid && a_out_ready) begin
            a_q_val.push_back(int'(a_out_pixel));
            a_q_last.push_back(int'(a_out_last));
            a_q_cyc.push_back(cyc);
        end
        if (a_in_valid && a_in_ready) a_acc_cyc.push_back(cyc);
        if (a_sof_err) a_sof_cnt++;
        if (b_out_valid && b_out_ready) begin
            b_q_val.push_back(int'(b_out_pixel));
            b_q_last.push_back(int'(b_out_last));
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one pixel to dut_a from a negedge, return at the negedge after acceptance.
    task automatic a_px(input int p, input logic sof);
        int  n;
        bit  done;
        a_in_pixel = 8'(p);
        a_in_sof   = sof;
        a_in_valid = 1'b1;
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            if (a_in_ready) done = 1;
            @(negedge clk);
        end
        cmp_cnt++;
        assert (done) else begin
            bad_cnt++;
            $error("FAIL a_accept_timeout: observed no accept expected accept of pixel %0d", p);
        end
        a_in_valid = 1'b0;
        a_in_sof   = 1'b0;
    endtask

    task automatic b_px(input int p, input logic sof);
        int  n;
        bit  done;
        b_in_pixel = 8'(p);
        b_in_sof   = sof;
        b_in_valid = 1'b1;
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            if (b_in_ready) done = 1;
            @(negedge clk);
        end
        cmp_cnt++;
        assert (done) else begin
            bad_cnt++;
            $error("FAIL b_accept_timeout: observed no accept expected accept of pixel %0d", p);
        end
        b_in_valid = 1'b0;
        b_in_sof   = 1'b0;
    endtask

    // Check four outputs recorded since index ob; only the fourth carries out_last.
    task automatic a_expect4(input string tag, input int ob,
                             input int e0, input int e1, input int e2, input int e3);
        int          e[4];
        logic [31:0] v;
        logic [31:0] l;
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, a_q_val.size() - ob, 4);
        for (int k = 0; k < 4; k++) begin
            if (ob + k < a_q_val.size()) begin
                v = a_q_val[ob + k];
                l = a_q_last[ob + k];
            end else begin
                v = 'x;
                l = 'x;
            end
            chk($sformatf("%s_val%0d", tag, k), v, e[k]);
            chk($sformatf("%s_last%0d", tag, k), l, (k == 3) ? 1 : 0);
        end
    endtask

    task automatic a_frame(input logic sof0);
        for (int i = 0; i < 16; i++) a_px(i, sof0 && (i == 0));
    endtask

    initial begin
        int ob, ab, sb, nbad, nlast;
        int idx[4];
        logic [31:0] lat;

        a_rst = 1'b0; a_mode = 1'b0; a_in_valid = 1'b0; a_in_sof = 1'b0;
        a_in_pixel = 8'd0; a_out_ready = 1'b1;
        b_rst = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_in_sof = 1'b0;
        b_in_pixel = 8'd0; b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_pixel", a_out_pixel, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_sof_err", a_sof_err, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        a_rst = 1'b1;
        b_rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1);

        // Average, 0..15 back-to-back: 2,4,10,12 one cycle after pixels 5,7,13,15
        ob = a_q_val.size();
        ab = a_acc_cyc.size();
        sb = a_sof_cnt;
        a_frame(1'b1);
        repeat (2) @(negedge clk);
        a_expect4("avg", ob, 2, 4, 10, 12);
        chk("avg_accepts", a_acc_cyc.size() - ab, 16);
        idx = '{5, 7, 13, 15};
        for (int k = 0; k < 4; k++) begin
            if ((ob + k < a_q_cyc.size()) && (ab + idx[k] < a_acc_cyc.size()))
                lat = a_q_cyc[ob + k] - a_acc_cyc[ab + idx[k]];
            else
                lat = 'x;
            chk($sformatf("avg_latency%0d", k), lat, 1);
        end
        chk("avg_no_sof_err", a_sof_cnt - sb, 0);

        // Max mode: 5,7,13,15
        a_mode = 1'b1;
        ob = a_q_val.size();
        a_frame(1'b1);
        repeat (2) @(negedge clk);
        a_expect4("max", ob, 5, 7, 13, 15);

        // Mode toggled to average mid-frame is ignored
        ob = a_q_val.size();
        for (int i = 0; i < 16; i++) begin
            if (i == 3) a_mode = 1'b0;
            a_px(i, i == 0);
        end
        repeat (2) @(negedge clk);
        a_expect4("max_toggle", ob, 5, 7, 13, 15);

        // Backpressure: out_ready low for 5 cycles after the first result
        a_mode = 1'b0;
        a_out_ready = 1'b0;
        ob = a_q_val.size();
        ab = a_acc_cyc.size();
        for (int i = 0; i < 6; i++) a_px(i, i == 0);
        a_in_pixel = 8'd6;
        a_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_in_ready%0d", c), a_in_ready, 0);
            chk($sformatf("bp_out_valid%0d", c), a_out_valid, 1);
            chk($sformatf("bp_out_pixel%0d", c), a_out_pixel, 2);
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        for (int i = 6; i < 16; i++) a_px(i, 1'b0);
        repeat (2) @(negedge clk);
        a_expect4("bp", ob, 2, 4, 10, 12);
        chk("bp_accepts", a_acc_cyc.size() - ab, 16);

        // In-frame restart after 6 pixels
        sb = a_sof_cnt;
        ob = a_q_val.size();
        for (int i = 0; i < 6; i++) a_px(i, i == 0);
        a_px(0, 1'b1);
        chk("sof_err_pulse", a_sof_err, 1);
        // Pixel 5 completed window (0,0) before the restart, so that result is genuine.
        chk("sof_pre_count", a_q_val.size() - ob, 1);
        chk("sof_pre_val", (ob < a_q_val.size()) ? a_q_val[ob] : 32'hFFFF_FFFF, 2);
        ob = a_q_val.size();
        for (int i = 1; i < 16; i++) begin
            a_px(i, 1'b0);
            if (i == 1) chk("sof_err_drop", a_sof_err, 0);
        end
        repeat (2) @(negedge clk);
        a_expect4("sof", ob, 2, 4, 10, 12);
        chk("sof_err_cycles", a_sof_cnt - sb, 1);

        // Reset after pixel 9, then a frame without in_sof
        for (int i = 0; i < 10; i++) a_px(i, i == 0);
        chk("mid_pixel_before_rst", a_out_pixel, 4);
        a_rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", a_out_valid, 0);
        chk("mid_rst_out_pixel", a_out_pixel, 0);
        @(negedge clk);
        a_rst = 1'b1;
        ob = a_q_val.size();
        a_frame(1'b0);
        repeat (2) @(negedge clk);
        a_expect4("post_rst", ob, 2, 4, 10, 12);

        // 28x28 all 255, average: 196 results of 255, last only on the 196th
        ob = b_q_val.size();
        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++)
                b_px(255, (x == 0) && (y == 0));
        repeat (2) @(negedge clk);
        chk("b255_count", b_q_val.size() - ob, 196);
        nbad = 0;
        nlast = 0;
        for (int k = ob; k < b_q_val.size(); k++) begin
            if (b_q_val[k] != 255) nbad++;
            if (b_q_last[k] != 0) nlast++;
        end
        chk("b255_values_off", nbad, 0);
        chk("b255_last_count", nlast, 1);
        chk("b255_last_pos", (ob + 195 < b_q_last.size()) ? b_q_last[ob + 195] : 0, 1);

        // Each window 1,1,1,4: floor(7/4) = 1
        ob = b_q_val.size();
        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++)
                b_px(((x % 2) == 1 && (y % 2) == 1) ? 4 : 1, (x == 0) && (y == 0));
        repeat (2) @(negedge clk);
        chk("b7_count", b_q_val.size() - ob, 196);
        nbad = 0;
        for (int k = ob; k < b_q_val.size(); k++)
            if (b_q_val[k] != 1) nbad++;
        chk("b7_values_off", nbad, 0);
        chk("b7_last_pos", (ob + 195 < b_q_last.size()) ? b_q_last[ob + 195] : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
